// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding instruction fetcher
// feeding an in-order instruction queue toward decode.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [31:0]              imem_data_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  output logic [31:0]              instr_pc4_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DISC = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_addr;
  logic            r_rst_done;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_mem_pc  [DEPTH];
  logic [31:0]     r_mem_ins [DEPTH];

  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_cnt_nxt;
  logic [31:0]     w_redir_pc;
  logic [31:0]     w_pc_inc;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & instr_ready_i;
  assign w_push     = (r_state == S_REQ) & imem_ack_i & ~redirect_i;
  assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_redir_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_pc_inc   = r_pc + 32'd4;

  // Fetch FSM: tracks the single outstanding read and the fetch address.
  // r_addr holds the address of the read in flight so it stays stable
  // even when a redirect moves r_pc during a discarded read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (redirect_i) begin
            r_state <= S_REQ;
            r_pc    <= w_redir_pc;
            r_addr  <= w_redir_pc;
          end else if (r_rst_done && (r_count < FULL)) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
        end
        S_REQ: begin
          if (redirect_i) begin
            r_pc <= w_redir_pc;
            if (imem_ack_i) begin
              r_state <= S_REQ;
              r_addr  <= w_redir_pc;
            end else begin
              r_state <= S_DISC;
            end
          end else if (imem_ack_i) begin
            r_pc <= w_pc_inc;
            if (w_cnt_nxt < FULL) begin
              r_state <= S_REQ;
              r_addr  <= w_pc_inc;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DISC: begin
          if (redirect_i) begin
            r_pc <= w_redir_pc;
            if (imem_ack_i) begin
              r_state <= S_REQ;
              r_addr  <= w_redir_pc;
            end
          end else if (imem_ack_i) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= w_cnt_nxt;
    end
  end

  // Entry storage; contents are masked at the outputs when empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_tail]  <= r_pc;
      r_mem_ins[r_tail] <= imem_data_i;
    end
  end

  assign imem_req_o    = (r_state != S_IDLE);
  assign imem_addr_o   = r_addr;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_mem_ins[r_head] : 32'd0;
  assign instr_pc_o    = w_valid ? r_mem_pc[r_head]  : 32'd0;
  assign instr_pc4_o   = instr_pc_o + 32'd4;
  assign count_o       = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic        ack = 1'b0;
  logic [31:0] data = 32'd0;
  logic        ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ivalid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic [31:0] ipc4;
  logic [2:0]  count;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst),
    .redirect_i(redirect), .redirect_pc_i(rpc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(ack), .imem_data_i(data),
    .instr_valid_o(ivalid), .instr_o(instr),
    .instr_pc_o(ipc), .instr_pc4_o(ipc4),
    .instr_ready_i(ready), .count_o(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: queue of fetched entries plus read bookkeeping
  logic [31:0] mq_pc[$];
  logic [31:0] mq_ins[$];
  bit          m_out;
  bit          m_keep;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_rdone;
  bit          pend;
  int          lat;

  typedef struct {
    bit          a;
    bit          rd;
    bit          er;
    logic [31:0] ea;
    bit          ev;
    logic [31:0] ep;
    int          ec;
  } vec_t;
  vec_t vt[$];

  function automatic logic [31:0] word(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_ins.delete();
    m_out = 0;
    m_keep = 0;
    m_pc = RPC;
    m_addr = RPC;
    m_rdone = 0;
  endtask

  task automatic model_step(input bit rdr, input logic [31:0] rp,
                            input bit a, input logic [31:0] d,
                            input bit rd);
    bit pop;
    int cnt0;
    logic [31:0] np;
    cnt0 = mq_pc.size();
    pop = (cnt0 != 0) && rd;
    if (rdr) begin
      mq_pc.delete();
      mq_ins.delete();
      np = {rp[31:2], 2'b00};
      m_pc = np;
      if (m_out && !a) begin
        m_keep = 0;
      end else begin
        m_out = 1;
        m_keep = 1;
        m_addr = np;
      end
    end else if (m_out && a) begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_ins.pop_front());
      end
      if (m_keep) begin
        mq_pc.push_back(m_addr);
        mq_ins.push_back(d);
        m_pc = m_pc + 32'd4;
        if (mq_pc.size() < DEPTH) m_addr = m_pc;
        else m_out = 0;
      end else begin
        m_keep = 1;
        m_addr = m_pc;
      end
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_ins.pop_front());
      end
      if (!m_out && m_rdone && cnt0 < DEPTH) begin
        m_out = 1;
        m_keep = 1;
        m_addr = m_pc;
      end
    end
    m_rdone = 1;
  endtask

  task automatic check_all();
    int n;
    logic [31:0] epc;
    logic [31:0] eins;
    n = mq_pc.size();
    epc = (n != 0) ? mq_pc[0] : 32'd0;
    eins = (n != 0) ? mq_ins[0] : 32'd0;
    chk("m.req", 32'(imem_req), 32'(m_out));
    if (m_out) chk("m.addr", imem_addr, m_addr);
    chk("m.valid", 32'(ivalid), 32'(n != 0));
    chk("m.count", 32'(count), 32'(n));
    chk("m.pc", ipc, epc);
    chk("m.instr", instr, eins);
    chk("m.pc4", ipc4, epc + 32'd4);
  endtask

  task automatic step(input bit rdr, input logic [31:0] rp,
                      input bit a, input logic [31:0] d, input bit rd);
    check_all();
    redirect = rdr;
    rpc = rp;
    ack = a;
    data = d;
    ready = rd;
    model_step(rdr, rp, a, d, rd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    ack = 1'b0;
    ready = 1'b0;
    pend = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.valid", 32'(ivalid), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.instr", instr, 32'd0);
    chk("rst.pc", ipc, 32'd0);
    rst = 1'b0;
  endtask

  task automatic addv(input bit a, input bit rd, input bit er,
                      input logic [31:0] ea, input bit ev,
                      input logic [31:0] ep, input int ec);
    vt.push_back('{a, rd, er, ea, ev, ep, ec});
  endtask

  initial begin
    bit          r_rdr;
    logic [31:0] r_rp;
    bit          r_ack;
    bit          r_rd;

    // back-to-back fetch, then fill to full with decode stalled
    addv(0, 1, 0, 32'd0,  0, 32'd0,  0);
    addv(0, 1, 0, 32'd0,  0, 32'd0,  0);
    addv(1, 1, 1, 32'd0,  0, 32'd0,  0);
    addv(1, 1, 1, 32'd4,  1, 32'd0,  1);
    addv(1, 1, 1, 32'd8,  1, 32'd4,  1);
    addv(1, 1, 1, 32'd12, 1, 32'd8,  1);
    addv(0, 1, 1, 32'd16, 1, 32'd12, 1);
    addv(1, 0, 1, 32'd16, 0, 32'd0,  0);
    addv(1, 0, 1, 32'd20, 1, 32'd16, 1);
    addv(1, 0, 1, 32'd24, 1, 32'd16, 2);
    addv(1, 0, 1, 32'd28, 1, 32'd16, 3);
    addv(0, 0, 0, 32'd0,  1, 32'd16, 4);
    addv(0, 1, 0, 32'd0,  1, 32'd16, 4);
    addv(0, 0, 0, 32'd0,  1, 32'd20, 3);
    addv(1, 0, 1, 32'd32, 1, 32'd20, 3);
    addv(0, 0, 0, 32'd0,  1, 32'd20, 4);
    addv(0, 1, 0, 32'd0,  1, 32'd20, 4);

    do_reset();
    foreach (vt[i]) begin
      chk($sformatf("t%0d.req", i), 32'(imem_req), 32'(vt[i].er));
      if (vt[i].er) chk($sformatf("t%0d.addr", i), imem_addr, vt[i].ea);
      chk($sformatf("t%0d.valid", i), 32'(ivalid), 32'(vt[i].ev));
      chk($sformatf("t%0d.count", i), 32'(count), 32'(vt[i].ec));
      if (vt[i].ev) begin
        chk($sformatf("t%0d.pc", i), ipc, vt[i].ep);
        chk($sformatf("t%0d.instr", i), instr, word(vt[i].ep));
      end
      step(0, 32'd0, vt[i].a, word(vt[i].ea), vt[i].rd);
    end

    // redirect while a slow read to 0x8 is in flight
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, word(32'd0), 1);
    step(0, 0, 1, word(32'd4), 1);
    chk("rd.addr8", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0);
    chk("rd.hold8", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("rd.addr40", imem_addr, 32'h40);
    chk("rd.cnt0", 32'(count), 32'd0);
    step(0, 0, 1, word(32'h40), 0);
    chk("rd.pc40", ipc, 32'h40);
    chk("rd.ins40", instr, word(32'h40));

    // redirect and pop together with three entries queued
    step(0, 0, 1, word(32'h44), 0);
    step(0, 0, 1, word(32'h48), 0);
    chk("rp.cnt3", 32'(count), 32'd3);
    step(1, 32'h100, 0, 0, 1);
    chk("rp.cnt0", 32'(count), 32'd0);
    chk("rp.val0", 32'(ivalid), 32'd0);
    step(0, 0, 1, 32'h0BAD_0BAD, 1);
    step(0, 0, 1, word(32'h100), 1);
    chk("rp.pc100", ipc, 32'h100);

    // redirect to the top of the address space, fetch wraps to 0
    step(1, 32'hFFFF_FFFE, 1, 32'h1111_1111, 0);
    chk("wr.addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, word(32'hFFFF_FFFC), 0);
    chk("wr.next", imem_addr, 32'h0);
    chk("wr.pc", ipc, 32'hFFFF_FFFC);
    chk("wr.pc4", ipc4, 32'h0);
    step(0, 0, 0, 0, 0);

    // asynchronous reset mid-read with two entries queued
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, word(32'd0), 0);
    step(0, 0, 1, word(32'd4), 0);
    chk("ar.cnt2", 32'(count), 32'd2);
    chk("ar.req", 32'(imem_req), 32'd1);
    #2 rst = 1'b1;
    ack = 1'b0;
    #1;
    chk("ar.req0", 32'(imem_req), 32'd0);
    chk("ar.val0", 32'(ivalid), 32'd0);
    chk("ar.cnt0", 32'(count), 32'd0);
    chk("ar.ins0", instr, 32'd0);
    chk("ar.pc0", ipc, 32'd0);
    model_reset();
    pend = 0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 32'hBAD0_BAD0, 1);
    chk("ar.stray", 32'(imem_req), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("ar.req1", 32'(imem_req), 32'd1);
    chk("ar.addr", imem_addr, RPC);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      r_rdr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        r_rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        r_rp = $urandom;
      r_ack = 0;
      if (m_out) begin
        if (!pend) begin
          pend = 1;
          lat = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        end
        if (lat == 0) begin
          r_ack = 1;
          pend = 0;
        end else begin
          lat--;
        end
      end else begin
        r_ack = ($urandom_range(0, 31) == 0);
      end
      r_rd = ($urandom_range(0, 9) < 7);
      step(r_rdr, r_rp, r_ack, $urandom, r_rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
